// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, lane count.
// Also hosts the misalignment predicate used when MISALIGN_TRAP_EN is defined.
package mem_access_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The reserved size 2'b11 behaves as a word, so size[1] alone selects word rules.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational little-endian lane logic: extracts and extends loads, merges sub-word stores.
// Low lane bits that are illegal for the size are dropped, so accesses align down.
module byte_lane_align
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mem_do,
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [1:0]       i_lane,
  input  logic [1:0]       i_size,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_merged
);

  localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(8'hFF);
  localparam logic [WIDTH-1:0] HALF_MASK = WIDTH'(16'hFFFF);

  logic [1:0]       w_lane;
  logic [4:0]       w_sh;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_data;

  always_comb begin
    w_lane = 2'b00;
    if (i_size == SZ_BYTE)      w_lane = i_lane;
    else if (i_size == SZ_HALF) w_lane = {i_lane[1], 1'b0};
    w_sh      = {w_lane, 3'b000};
    w_shifted = i_mem_do >> w_sh;

    o_load = i_mem_do;
    if (i_size == SZ_BYTE)
      o_load = {{(WIDTH-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
    else if (i_size == SZ_HALF)
      o_load = {{(WIDTH-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};

    w_mask = '1;
    if (i_size == SZ_BYTE)      w_mask = BYTE_MASK << w_sh;
    else if (i_size == SZ_HALF) w_mask = HALF_MASK << w_sh;
    // Store data is right-justified; upper WDATA bits never reach memory.
    w_data   = i_wdata << w_sh;
    o_merged = (i_old & ~w_mask) | (w_data & w_mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-addressed load/store sequencer over a word-wide memory; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned requests finish immediately with ERR instead of aligning down.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WR,
  input  logic [1:0]        SIZE,
  input  logic              SIGNED,
  input  logic [ADDR_W+1:0] BADDR,
  input  logic [WIDTH-1:0]  WDATA,
  output logic [WIDTH-1:0]  RDATA,
  output logic              DONE,
  output logic              BUSY,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [WIDTH-1:0]  MEM_WDI,
  output logic              MEM_WE,
  input  logic [WIDTH-1:0]  MEM_DO
);

  state_t            r_state, w_next;
  logic              r_wr, r_signed;
  logic [1:0]        r_size, r_lane;
  logic [WIDTH-1:0]  r_wdata, r_rdata, r_rmw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_subword, w_trap, w_we;
  logic [WIDTH-1:0]  w_load, w_merged, w_wdi;

  byte_lane_align #(.WIDTH(WIDTH)) u_align (
    .i_mem_do (MEM_DO),
    .i_old    (r_rmw),
    .i_wdata  (r_wdata),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign w_subword = (r_size == SZ_BYTE) || (r_size == SZ_HALF);
`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(SIZE, BADDR[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_wdi  = r_rmw;
    case (r_state)
      ST_IDLE:   if (REQ) w_next = w_trap ? ST_DONE : ST_ACCESS;
      ST_ACCESS: begin
        w_next = (r_wr && w_subword) ? ST_WRITE : ST_DONE;
        if (r_wr && !w_subword) begin
          w_we  = 1'b1;
          w_wdi = r_wdata;
        end
      end
      ST_WRITE: begin
        w_next = ST_DONE;
        w_we   = 1'b1;
        w_wdi  = w_merged;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_wr       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rmw      <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && REQ) begin
        r_wr       <= WR;
        r_size     <= SIZE;
        r_signed   <= SIGNED;
        r_lane     <= BADDR[1:0];
        r_wdata    <= WDATA;
        r_mem_addr <= BADDR[ADDR_W+1:2];
      end
      if (r_state == ST_ACCESS) begin
        if (!r_wr)          r_rdata <= w_load;
        else if (w_subword) r_rmw   <= MEM_DO;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge CLK) begin
    if (!RST_N)                           r_err <= 1'b0;
    else if (r_state == ST_IDLE && REQ)   r_err <= w_trap;
    else if (r_state == ST_DONE)          r_err <= 1'b0;
  end
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  // Gating with RST_N keeps a reset edge from committing a half-finished store.
  assign MEM_WE   = w_we & RST_N;
  assign MEM_WDI  = w_wdi;
  assign RDATA    = r_rdata;
  assign DONE     = (r_state == ST_DONE);
  assign BUSY     = (r_state != ST_IDLE);
  assign MEM_ADDR = r_mem_addr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl with a behavioural word memory.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, REQ, WR, SIGNED, DONE, BUSY, ERR, MEM_WE;
  logic [1:0]  SIZE;
  logic [6:0]  BADDR;
  logic [31:0] WDATA, RDATA, MEM_WDI, MEM_DO;
  logic [4:0]  MEM_ADDR;
  logic [31:0] mem [32];

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.WIDTH(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WR(WR), .SIZE(SIZE), .SIGNED(SIGNED),
    .BADDR(BADDR), .WDATA(WDATA), .RDATA(RDATA), .DONE(DONE), .BUSY(BUSY), .ERR(ERR),
    .MEM_ADDR(MEM_ADDR), .MEM_WDI(MEM_WDI), .MEM_WE(MEM_WE), .MEM_DO(MEM_DO)
  );

  assign MEM_DO = mem[MEM_ADDR];
  always @(posedge CLK) if (MEM_WE) mem[MEM_ADDR] <= MEM_WDI;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [6:0]  baddr;
    logic [31:0] wdata;
    logic        upd;       // load result expected to land in RDATA
    logic [31:0] exp_rdata;
    logic [4:0]  widx;      // memory word checked after completion
    logic [31:0] exp_word;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t        vt [17];
  int          n_vec = 0, n_checks = 0, n_miscmp = 0;
  logic [31:0] exp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [6:0] baddr, input logic [31:0] wdata,
                              input logic upd, input logic [31:0] exp_rdata,
                              input logic [4:0] widx, input logic [31:0] exp_word,
                              input int exp_lat, input logic exp_err);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.baddr = baddr; v.wdata = wdata;
    v.upd = upd; v.exp_rdata = exp_rdata; v.widx = widx; v.exp_word = exp_word;
    v.exp_lat = exp_lat; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic apply(input int idx);
    vec_t v = vt[idx];
    int   lat = 0, we = 0;
    n_vec++;
    @(negedge CLK);
    REQ = 1'b1; WR = v.wr; SIZE = v.size; SIGNED = v.sgn; BADDR = v.baddr; WDATA = v.wdata;
    @(posedge CLK); #1 REQ = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      if (lat == 0) begin
        @(negedge CLK);
        if (MEM_WE === 1'b1) begin
          we++;
          chk($sformatf("v%0d_we_addr", idx), {27'd0, MEM_ADDR}, {27'd0, v.baddr[6:2]});
          chk($sformatf("v%0d_we_data", idx), MEM_WDI, v.exp_word);
        end
        if (DONE === 1'b1) lat = n;
        else chk($sformatf("v%0d_busy", idx), {31'd0, BUSY}, 32'd1);
      end
    end
    if (v.upd) exp_rd = v.exp_rdata;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_we_cycles", idx), we, (v.wr && !v.exp_err) ? 1 : 0);
    chk($sformatf("v%0d_err", idx), {31'd0, ERR}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rdata", idx), RDATA, exp_rd);
    @(posedge CLK); #1;
    chk($sformatf("v%0d_mem", idx), mem[v.widx], v.exp_word);
    chk($sformatf("v%0d_done_clr", idx), {30'd0, DONE, ERR}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[3] = 32'hCAFEF00D;
    RST_N = 1'b0; REQ = 1'b0; WR = 1'b0; SIZE = 2'b00; SIGNED = 1'b0; BADDR = '0; WDATA = '0;
    exp_rd = 32'd0;

    vt[0]  = mk(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 0, 0,            2, 32'hDEADBEEF, 2, 0);
    vt[1]  = mk(1, 2'b00, 0, 7'h09, 32'h000000AA, 0, 0,            2, 32'hDEADAAEF, 3, 0);
    vt[2]  = mk(0, 2'b00, 1, 7'h0B, 32'h0,        1, 32'hFFFFFFDE, 2, 32'hDEADAAEF, 2, 0);
    vt[3]  = mk(0, 2'b00, 0, 7'h0B, 32'h0,        1, 32'h000000DE, 2, 32'hDEADAAEF, 2, 0);
    vt[4]  = mk(0, 2'b01, 1, 7'h0A, 32'h0,        1, 32'hFFFFDEAD, 2, 32'hDEADAAEF, 2, 0);
    vt[5]  = mk(1, 2'b01, 0, 7'h0A, 32'h00001234, 0, 0,            2, 32'h1234AAEF, 3, 0);
    vt[6]  = mk(0, 2'b10, 0, 7'h08, 32'h0,        1, 32'h1234AAEF, 2, 32'h1234AAEF, 2, 0);
    vt[7]  = mk(0, 2'b01, 0, 7'h08, 32'h0,        1, 32'h0000AAEF, 2, 32'h1234AAEF, 2, 0);
    vt[8]  = mk(0, 2'b00, 1, 7'h08, 32'h0,        1, 32'hFFFFFFEF, 2, 32'h1234AAEF, 2, 0);
    vt[9]  = mk(0, 2'b01, 1, 7'h0E, 32'h0,        1, 32'hFFFFCAFE, 3, 32'hCAFEF00D, 2, 0);
    vt[10] = mk(0, 2'b00, 0, 7'h0C, 32'h0,        1, 32'h0000000D, 3, 32'hCAFEF00D, 2, 0);
    vt[11] = mk(1, 2'b00, 0, 7'h0E, 32'hFFFFFF80, 0, 0,            3, 32'hCA80F00D, 3, 0);
    vt[12] = mk(0, 2'b00, 1, 7'h0E, 32'h0,        1, 32'hFFFFFF80, 3, 32'hCA80F00D, 2, 0);
    vt[13] = mk(0, 2'b11, 0, 7'h0C, 32'h0,        1, 32'hCA80F00D, 3, 32'hCA80F00D, 2, 0);
`ifdef MISALIGN_TRAP_EN
    vt[14] = mk(0, 2'b10, 0, 7'h0D, 32'h0,        0, 0,            3, 32'hCA80F00D, 1, 1);
    vt[15] = mk(1, 2'b01, 0, 7'h0B, 32'h0000BEEF, 0, 0,            2, 32'h1234AAEF, 1, 1);
    vt[16] = mk(0, 2'b01, 1, 7'h0F, 32'h0,        0, 0,            3, 32'hCA80F00D, 1, 1);
`else
    vt[14] = mk(0, 2'b10, 0, 7'h0D, 32'h0,        1, 32'hCA80F00D, 3, 32'hCA80F00D, 2, 0);
    vt[15] = mk(1, 2'b01, 0, 7'h0B, 32'h0000BEEF, 0, 0,            2, 32'hBEEFAAEF, 3, 0);
    vt[16] = mk(0, 2'b01, 1, 7'h0F, 32'h0,        1, 32'hFFFFCA80, 3, 32'hCA80F00D, 2, 0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    n_vec++;
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_flags", {28'd0, DONE, BUSY, ERR, MEM_WE}, 32'd0);
    chk("rst_addr", {27'd0, MEM_ADDR}, 32'd0);
    chk("rst_wdi", MEM_WDI, 32'd0);
    @(negedge CLK); RST_N = 1'b1;

    for (int i = 0; i <= 13; i++) apply(i);

    // Reset asserted while a byte store sits in WRITE.
    n_vec++;
    @(negedge CLK);
    REQ = 1'b1; WR = 1'b1; SIZE = 2'b00; SIGNED = 1'b0; BADDR = 7'h09; WDATA = 32'h77;
    @(posedge CLK); #1 REQ = 1'b0;
    @(negedge CLK);
    chk("rmw_read_no_we", {31'd0, MEM_WE}, 32'd0);
    @(negedge CLK);
    chk("write_we_before_rst", {31'd0, MEM_WE}, 32'd1);
    RST_N = 1'b0; #1;
    chk("write_we_gated", {31'd0, MEM_WE}, 32'd0);
    @(negedge CLK);
    chk("abort_flags", {29'd0, DONE, BUSY, ERR}, 32'd0);
    chk("abort_rdata", RDATA, 32'd0);
    chk("abort_mem", mem[2], 32'h1234AAEF);
    RST_N = 1'b1;
    exp_rd = 32'd0;

    // REQ held high across two word loads: second starts only after DONE returns to IDLE.
    n_vec++;
    @(negedge CLK);
    REQ = 1'b1; WR = 1'b0; SIZE = 2'b10; SIGNED = 1'b0; BADDR = 7'h08; WDATA = 32'h0;
    @(posedge CLK);
    for (int n = 1; n <= 5; n++) begin
      @(negedge CLK);
      chk($sformatf("b2b_done_c%0d", n), {31'd0, DONE}, (n == 2 || n == 5) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_busy_c%0d", n), {31'd0, BUSY}, (n == 3) ? 32'd0 : 32'd1);
    end
    REQ = 1'b0;
    chk("b2b_rdata", RDATA, 32'h1234AAEF);
    exp_rd = 32'h1234AAEF;
    @(negedge CLK);

    for (int i = 14; i <= 16; i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
